// File: rtl/shift_reg_universal_if.sv
// Bus bundle for shift_reg_universal: control/data inputs plus register taps.
// BitCount/Empty exist only when SHIFT_CNT_EN is defined.
interface shift_reg_universal_if #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
);
  logic             En;
  logic [2:0]       Mode;
  logic             ShiftIn;
  logic [WIDTH-1:0] ParIn;
  logic [WIDTH-1:0] Q;
  logic             ShiftOutR;
  logic             ShiftOutL;
`ifdef SHIFT_CNT_EN
  logic [CW-1:0]    BitCount;
  logic             Empty;

  modport master (
    output En, Mode, ShiftIn, ParIn,
    input  Q, ShiftOutR, ShiftOutL, BitCount, Empty
  );

  modport slave (
    input  En, Mode, ShiftIn, ParIn,
    output Q, ShiftOutR, ShiftOutL, BitCount, Empty
  );
`else
  modport master (
    output En, Mode, ShiftIn, ParIn,
    input  Q, ShiftOutR, ShiftOutL
  );

  modport slave (
    input  En, Mode, ShiftIn, ParIn,
    output Q, ShiftOutR, ShiftOutL
  );
`endif
endinterface

// File: rtl/shift_reg_universal.sv
// Universal shift register: hold, shift L/R, rotate L/R, parallel load, clear.
// Optional shift counter (BitCount/Empty) enabled by defining SHIFT_CNT_EN.
module shift_reg_universal #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                   Clk,
  input  logic                   ResetN,
  shift_reg_universal_if.slave   bus
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHR  = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_ROR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_LOAD = 3'b101,
    MODE_CLR  = 3'b110,
    MODE_RSVD = 3'b111
  } mode_t;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] shr_v;
  logic [WIDTH-1:0] shl_v;
  logic [WIDTH-1:0] ror_v;
  logic [WIDTH-1:0] rol_v;
  mode_t            mode;

  assign mode = mode_t'(bus.Mode);

  // Per-bit neighbour selection; the end bits take either the serial input or the wrapped bit.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == WIDTH - 1) begin : g_msb
        assign shr_v[gi] = bus.ShiftIn;
        assign ror_v[gi] = q_q[0];
      end else begin : g_upper
        assign shr_v[gi] = q_q[gi+1];
        assign ror_v[gi] = q_q[gi+1];
      end

      if (gi == 0) begin : g_lsb
        assign shl_v[gi] = bus.ShiftIn;
        assign rol_v[gi] = q_q[WIDTH-1];
      end else begin : g_lower
        assign shl_v[gi] = q_q[gi-1];
        assign rol_v[gi] = q_q[gi-1];
      end
    end
  endgenerate

  // Mode is only looked at under En, so an undefined Mode while disabled is harmless.
  always_comb begin
    q_d = q_q;
    if (bus.En) begin
      case (mode)
        MODE_SHR:  q_d = shr_v;
        MODE_SHL:  q_d = shl_v;
        MODE_ROR:  q_d = ror_v;
        MODE_ROL:  q_d = rol_v;
        MODE_LOAD: q_d = bus.ParIn;
        MODE_CLR:  q_d = RESET_VAL;
        default:   q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign bus.Q         = q_q;
  assign bus.ShiftOutR = q_q[0];
  assign bus.ShiftOutL = q_q[WIDTH-1];

`ifdef SHIFT_CNT_EN
  localparam int               CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(WIDTH);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          empty_q;
  logic          empty_d;
  logic          shift_op;
  logic          restart_op;

  always_comb begin
    shift_op   = 1'b0;
    restart_op = 1'b0;
    if (bus.En) begin
      case (mode)
        MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL: shift_op   = 1'b1;
        MODE_LOAD, MODE_CLR:                    restart_op = 1'b1;
        default: ;
      endcase
    end
  end

  // Counter saturates at WIDTH, so Empty stays asserted until a load or clear.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_op) begin
      cnt_d = '0;
    end else if (shift_op && (cnt_q != CNT_FULL)) begin
      cnt_d = cnt_q + 1'b1;
    end
    empty_d = (cnt_d == CNT_FULL);
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      cnt_q   <= '0;
      empty_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
    end
  end

  assign bus.BitCount = cnt_q;
  assign bus.Empty    = empty_q;
`endif

endmodule
